// File: rtl/transformation_controller_if.sv
// transformation_controller_if
//   Handshake/bus bundle between the transformation controller and its
//   memories / product sink.
//   master : controller side (drives requests, addresses and write strobes)
//   slave  : environment side (drives start and rd_valid)
//   Signals: start, rd_valid, rd_req, rd_sel, weight_addr, feature_addr,
//            scratch_we, prod_we, prod_row, prod_col, busy, done
//            (+ stall_cycles when TRANSFORM_PERF_CNT_EN is defined)
interface transformation_controller_if #(
  parameter int FEATURE_ROWS = 6,
  parameter int WEIGHT_COLS  = 3
);
  localparam int CFW = (FEATURE_ROWS > 1) ? $clog2(FEATURE_ROWS) : 1;
  localparam int CWW = (WEIGHT_COLS > 1) ? $clog2(WEIGHT_COLS) : 1;

  logic           start;
  logic           rd_valid;
  logic           rd_req;
  logic           rd_sel;
  logic [CWW-1:0] weight_addr;
  logic [CFW-1:0] feature_addr;
  logic           scratch_we;
  logic           prod_we;
  logic [CFW-1:0] prod_row;
  logic [CWW-1:0] prod_col;
  logic           busy;
  logic           done;
`ifdef TRANSFORM_PERF_CNT_EN
  logic [31:0]    stall_cycles;

  modport master (input start, rd_valid,
                  output rd_req, rd_sel, weight_addr, feature_addr, scratch_we,
                         prod_we, prod_row, prod_col, busy, done, stall_cycles);
  modport slave  (output start, rd_valid,
                  input rd_req, rd_sel, weight_addr, feature_addr, scratch_we,
                        prod_we, prod_row, prod_col, busy, done, stall_cycles);
`else
  modport master (input start, rd_valid,
                  output rd_req, rd_sel, weight_addr, feature_addr, scratch_we,
                         prod_we, prod_row, prod_col, busy, done);
  modport slave  (output start, rd_valid,
                  input rd_req, rd_sel, weight_addr, feature_addr, scratch_we,
                        prod_we, prod_row, prod_col, busy, done);
`endif
endinterface

// File: rtl/transformation_controller.sv
// transformation_controller
//   Sequences FM[FEATURE_ROWS][*] x W[*][WEIGHT_COLS]: for each weight column,
//   fetch the column into the scratch pad, then stream every feature row and
//   issue one product write per (row, col), column-major. done pulses once per
//   job and the block returns to IDLE.
// Ports
//   clk   : clock, posedge
//   reset : synchronous, active-high
//   bus   : transformation_controller_if.master (start/rd handshake, addresses,
//           write strobes, busy/done)
// Optional feature: define TRANSFORM_PERF_CNT_EN to add bus.stall_cycles, a
//   saturating count of cycles with rd_req=1 && rd_valid=0 for the current job.
module transformation_controller #(
  parameter int FEATURE_ROWS = 6,
  parameter int WEIGHT_COLS  = 3
) (
  input  logic clk,
  input  logic reset,
  transformation_controller_if.master bus
);
  localparam int COUNTER_FEATURE_WIDTH = (FEATURE_ROWS > 1) ? $clog2(FEATURE_ROWS) : 1;
  localparam int COUNTER_WEIGHT_WIDTH  = (WEIGHT_COLS > 1) ? $clog2(WEIGHT_COLS) : 1;
  localparam int CFW = COUNTER_FEATURE_WIDTH;
  localparam int CWW = COUNTER_WEIGHT_WIDTH;

  localparam logic [CFW-1:0] ROW_LAST = CFW'(FEATURE_ROWS - 1);
  localparam logic [CWW-1:0] COL_LAST = CWW'(WEIGHT_COLS - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LOAD_W = 3'd1;
  localparam logic [2:0] READ_F = 3'd2;
  localparam logic [2:0] WRITE  = 3'd3;
  localparam logic [2:0] DONE   = 3'd4;

  logic [2:0]     state;
  logic [CFW-1:0] r;
  logic [CWW-1:0] c;
  logic           last_row;
  logic           last_col;

  assign last_row = (r == ROW_LAST);
  assign last_col = (c == COL_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      r     <= '0;
      c     <= '0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          state <= LOAD_W;
          r     <= '0;
          c     <= '0;
        end
        LOAD_W: if (bus.rd_valid) state <= READ_F;
        READ_F: if (bus.rd_valid) state <= WRITE;
        WRITE: begin
          if (last_row && last_col) begin
            state <= DONE;
          end else if (last_row) begin
            // column finished: refetch the next weight column
            r     <= '0;
            c     <= c + CWW'(1);
            state <= LOAD_W;
          end else begin
            r     <= r + CFW'(1);
            state <= READ_F;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // All outputs are decoded from state/counters; rd_valid only gates the
  // scratch pad latch so the column is captured in the handshake cycle.
  assign bus.busy         = (state != IDLE);
  assign bus.rd_req       = (state == LOAD_W) || (state == READ_F);
  assign bus.rd_sel       = (state == READ_F) || (state == WRITE);
  assign bus.scratch_we   = (state == LOAD_W) && bus.rd_valid;
  assign bus.prod_we      = (state == WRITE);
  // counters keep their last values after DONE, so mask them in IDLE
  assign bus.weight_addr  = bus.busy ? c : '0;
  assign bus.feature_addr = bus.busy ? r : '0;
  assign bus.prod_row     = bus.busy ? r : '0;
  assign bus.prod_col     = bus.busy ? c : '0;
  assign bus.done         = (state == DONE);

`ifdef TRANSFORM_PERF_CNT_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk) begin
    if (reset || (state == IDLE && bus.start))
      stall_q <= '0;
    else if (bus.rd_req && !bus.rd_valid && (stall_q != 32'hFFFF_FFFF))
      stall_q <= stall_q + 32'd1;
  end

  assign bus.stall_cycles = stall_q;
`endif
endmodule
